// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock-enable generator.
// Divisor defaults assume a 50 MHz clk.
package clk_div_pkg;

  localparam int unsigned DEF_CNT_W     = 32;
  localparam int unsigned DEF_SUB_W     = 4;
  localparam int unsigned DEF_DIV_500MS = 25_000_000;
  localparam int unsigned DEF_DIV_1MS   = 50_000;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: runtime divisor latched at period boundaries,
// one-cycle tick, toggling wave, wrapping tick sub-counter and zero-divisor halt.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W   = DEF_CNT_W,
  parameter int unsigned      SUB_W   = DEF_SUB_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_500MS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div_in,
  output logic             tick,
  output logic             wave,
  output logic [SUB_W-1:0] sub_cnt,
  output logic             div_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SUB_W-1:0] SUB_ONE = SUB_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_lat_q, div_lat_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             tick_q, tick_d;
  logic             wave_q, wave_d;
  logic             div_err_q, div_err_d;

  always_comb begin
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    wave_d    = wave_q;
    sub_cnt_d = sub_cnt_q;
    div_lat_d = div_lat_q;
    div_err_d = div_err_q;
    if (clr) begin
      cnt_d     = '0;
      wave_d    = 1'b0;
      sub_cnt_d = '0;
      div_lat_d = div_in;
      div_err_d = div_err_q && (div_in == '0);
    end else if (div_lat_q == '0) begin
      // Halted, but an idle channel keeps tracking div_in so it can recover without clr.
      div_err_d = 1'b1;
      if (!en) begin
        div_lat_d = div_in;
        div_err_d = (div_in == '0);
      end
    end else if (step) begin
      if (cnt_q == div_lat_q - CNT_ONE) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        wave_d    = ~wave_q;
        sub_cnt_d = sub_cnt_q + SUB_ONE;
        div_lat_d = div_in;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (!en) begin
      div_lat_d = div_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_lat_q <= DEF_DIV;
      sub_cnt_q <= '0;
      tick_q    <= 1'b0;
      wave_q    <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      sub_cnt_q <= sub_cnt_d;
      tick_q    <= tick_d;
      wave_q    <= wave_d;
      div_err_q <= div_err_d;
    end
  end

  assign tick    = tick_q;
  assign wave    = wave_q;
  assign sub_cnt = sub_cnt_q;
  assign div_err = div_err_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable generator; ticks are enables for downstream logic.
// With CASCADE=1 channel i>0 advances once per registered tick of channel i-1.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned SUB_W   = DEF_SUB_W,
  parameter int unsigned DEF_DIV = DEF_DIV_500MS,
  parameter int unsigned CASCADE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       wave,
  output logic [NUM_CH*SUB_W-1:0] sub_cnt,
  output logic [NUM_CH-1:0]       div_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic step;

    if ((CASCADE != 0) && (i > 0)) begin : g_casc
      assign step = en[i] & tick[i-1];
    end else begin : g_free
      assign step = en[i];
    end

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .SUB_W   (SUB_W),
      .DEF_DIV (CNT_W'(DEF_DIV))
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .step    (step),
      .en      (en[i]),
      .clr     (clr[i]),
      .div_in  (div_in[i*CNT_W +: CNT_W]),
      .tick    (tick[i]),
      .wave    (wave[i]),
      .sub_cnt (sub_cnt[i*SUB_W +: SUB_W]),
      .div_err (div_err[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: one free-running and one cascaded instance share stimulus
// and are compared every cycle against a per-channel reference model.
module tb_clk_div_multi;

  logic        clk, rst_n;
  logic [63:0] div_in;
  logic [1:0]  en, clr;
  logic [1:0]  tick_a, wave_a, err_a, tick_b, wave_b, err_b;
  logic [7:0]  sub_a, sub_b;

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_multi #(.NUM_CH(2), .CNT_W(32), .SUB_W(4), .DEF_DIV(4), .CASCADE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .en(en), .clr(clr),
    .tick(tick_a), .wave(wave_a), .sub_cnt(sub_a), .div_err(err_a)
  );

  clk_div_multi #(.NUM_CH(2), .CNT_W(32), .SUB_W(4), .DEF_DIV(4), .CASCADE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .en(en), .clr(clr),
    .tick(tick_b), .wave(wave_b), .sub_cnt(sub_b), .div_err(err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state per [instance][channel]; instance 1 is the cascaded one.
  int unsigned m_cnt [2][2];
  int unsigned m_lat [2][2];
  int unsigned m_sub [2][2];
  bit          m_tick[2][2];
  bit          m_wave[2][2];
  bit          m_err [2][2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        m_cnt[d][c] = 0; m_lat[d][c] = 4; m_sub[d][c] = 0;
        m_tick[d][c] = 0; m_wave[d][c] = 0; m_err[d][c] = 0;
      end
  endtask

  task automatic model_edge();
    bit          old_tick[2][2];
    int unsigned din;
    bit          step;
    old_tick = m_tick;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        din  = div_in[c*32 +: 32];
        step = en[c];
        if (d == 1 && c > 0) step = en[c] && old_tick[d][c-1];
        m_tick[d][c] = 0;
        if (clr[c]) begin
          m_cnt[d][c] = 0; m_wave[d][c] = 0; m_sub[d][c] = 0;
          m_lat[d][c] = din;
          m_err[d][c] = m_err[d][c] && (din == 0);
        end else if (m_lat[d][c] == 0) begin
          m_err[d][c] = 1;
          if (!en[c]) begin
            m_lat[d][c] = din;
            m_err[d][c] = (din == 0);
          end
        end else if (step) begin
          if (m_cnt[d][c] + 1 == m_lat[d][c]) begin
            m_cnt[d][c]  = 0;
            m_tick[d][c] = 1;
            m_wave[d][c] = !m_wave[d][c];
            m_sub[d][c]  = (m_sub[d][c] + 1) % 16;
            m_lat[d][c]  = din;
          end else begin
            m_cnt[d][c] = m_cnt[d][c] + 1;
          end
        end else if (!en[c]) begin
          m_lat[d][c] = din;
        end
      end
  endtask

  function automatic logic [13:0] model_vec(input int d);
    logic [3:0] s0, s1;
    s0 = 4'(m_sub[d][0]);
    s1 = 4'(m_sub[d][1]);
    return {m_tick[d][1], m_tick[d][0], m_wave[d][1], m_wave[d][0], s1, s0, m_err[d][1], m_err[d][0]};
  endfunction

  task automatic check_model();
    chk("model_free", {tick_a, wave_a, sub_a, err_a}, model_vec(0));
    chk("model_casc", {tick_b, wave_b, sub_b, err_b}, model_vec(1));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_div(input int unsigned d0, input int unsigned d1);
    div_in = {d1, d0};
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  clr;
    int unsigned d0, d1;
    logic [1:0]  e_tick;
    logic [1:0]  e_wave;
    logic [3:0]  e_sub;
  } vec_t;

  vec_t tbl[8];

  initial begin
    rst_n = 1'b0; en = 2'b11; clr = 2'b00; set_div(4, 4);
    model_reset();

    // Edges 1..8 after reset release at divisor 4.
    tbl[0] = '{2'b11, 2'b00, 4, 4, 2'b00, 2'b00, 4'd0};
    tbl[1] = '{2'b11, 2'b00, 4, 4, 2'b00, 2'b00, 4'd0};
    tbl[2] = '{2'b11, 2'b00, 4, 4, 2'b00, 2'b00, 4'd0};
    tbl[3] = '{2'b11, 2'b00, 4, 4, 2'b11, 2'b11, 4'd1};
    tbl[4] = '{2'b11, 2'b00, 4, 4, 2'b00, 2'b11, 4'd1};
    tbl[5] = '{2'b11, 2'b00, 4, 4, 2'b00, 2'b11, 4'd1};
    tbl[6] = '{2'b11, 2'b00, 4, 4, 2'b00, 2'b11, 4'd1};
    tbl[7] = '{2'b11, 2'b00, 4, 4, 2'b11, 2'b00, 4'd2};

    // Scenario 1: reset values, basic rate, sub_cnt wrap.
    do_reset();
    chk("rst_outputs", {tick_a, wave_a, sub_a, err_a}, 14'd0);
    for (int i = 0; i < 8; i++) begin
      en = tbl[i].en; clr = tbl[i].clr; set_div(tbl[i].d0, tbl[i].d1);
      cycle();
      chk("tbl_tick", tick_a, tbl[i].e_tick);
      chk("tbl_wave", wave_a, tbl[i].e_wave);
      chk("tbl_sub", sub_a, {tbl[i].e_sub, tbl[i].e_sub});
    end
    for (int e = 9; e <= 64; e++) begin
      cycle();
      if (e == 60) chk("s1_sub15", sub_a, 8'hff);
      if (e == 64) chk("s1_wrap", {wave_a, sub_a}, 10'd0);
    end

    // Scenario 2: divisor change mid-period applies at the next boundary.
    cycle(); cycle();
    set_div(2, 4);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk("s2_tick0", tick_a[0], (k % 2) == 0);
      chk("s2_tick1", tick_a[1], (k == 2) || (k == 6));
    end

    // Scenario 3: cascade, divisors 4 and 3 loaded while idle.
    en = 2'b00; set_div(4, 3);
    do_reset();
    cycle();
    en = 2'b11;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      chk("s3_tick0", tick_b[0], (k % 4) == 0);
      chk("s3_tick1", tick_b[1], (k > 1) && ((k % 12) == 1));
    end

    // Scenario 4: enable gap at cnt=2.
    en = 2'b11; set_div(4, 4);
    do_reset();
    cycle(); cycle();
    en = 2'b10;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("s4_gap", tick_a[0], 1'b0);
    end
    en = 2'b11;
    cycle(); chk("s4_resume1", tick_a[0], 1'b0);
    cycle(); chk("s4_resume2", tick_a[0], 1'b1);

    // Scenario 5: zero divisor halts, clr with a valid divisor recovers.
    en = 2'b00; set_div(0, 4);
    do_reset();
    cycle(); cycle();
    en = 2'b11;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("s5_halt", {tick_a[0], err_a[0]}, 2'b01);
    end
    clr = 2'b01; set_div(3, 4);
    cycle();
    chk("s5_clr_err", err_a[0], 1'b0);
    clr = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk("s5_tick", tick_a[0], (k % 3) == 0);
    end

    // Scenario 6: clr on terminal edge, then reset mid-period.
    en = 2'b11; set_div(4, 4);
    do_reset();
    cycle(); cycle(); cycle();
    clr = 2'b01;
    cycle();
    chk("s6_clr_wins", {tick_a[0], wave_a[0], sub_a[3:0]}, 6'd0);
    chk("s6_ch1_tick", tick_a[1], 1'b1);
    clr = 2'b00;
    cycle(); cycle();
    set_div(7, 7);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_mid", {tick_a, wave_a, sub_a, err_a}, 14'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cycle();
      chk("s6_post_rst", tick_a[0], (k == 4) || (k == 11));
    end

    // Randomized run against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      en  = {($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8)};
      clr = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
      if ($urandom_range(0, 9) == 0) div_in[31:0]  = $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) div_in[63:32] = $urandom_range(0, 5);
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
